pc_return_stack: RTL and testbench

- Return-address stack (RAS) for the multicycle CPU; the link/return counterpart of the J-type jump-target path.
- On JAL the control FSM pushes the link address (PC+4); on JR $ra it pops and supplies the predicted return target to the PC-source mux.
- Circular storage with depth counter, overflow/underflow flags and flush from control.

---
 rtl/cpu_pkg.sv | 22 ++
 rtl/ras_storage.sv | 33 +++
 rtl/pc_return_stack.sv | 138 +++++++++++++
 tb/tb_pc_return_stack.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: address width, RAS defaults, PC-source select.
// Used by the return-address stack and the PC-source mux.
package cpu_pkg;

  localparam int ADDR_W = 32;
  localparam int RAS_DEPTH_DEF = 8;
  localparam logic [1:0] INSTR_ALIGN = 2'b00;

  typedef enum logic [1:0] {
    PCSRC_ALU    = 2'd0,
    PCSRC_ALUOUT = 2'd1,
    PCSRC_JUMP   = 2'd2,
    PCSRC_RAS    = 2'd3
  } pc_src_e;

  function automatic logic addr_aligned(
    input logic [ADDR_W-1:0] a
  );
    return a[1:0] == INSTR_ALIGN;
  endfunction

endpackage

// File: rtl/ras_storage.sv
// Return-address entry array: one write port, one async read port.
// Entries clear to zero on reset.
module ras_storage
  import cpu_pkg::*;
#(
  parameter int DEPTH = RAS_DEPTH_DEF,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              we_i,
  input  logic [PTR_W-1:0]  waddr_i,
  input  logic [ADDR_W-1:0] wdata_i,
  input  logic [PTR_W-1:0]  raddr_i,
  output logic [ADDR_W-1:0] rdata_o
);

  logic [ADDR_W-1:0] mem_q [DEPTH];

  // Entry write on the rising edge; async clear of every entry.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/pc_return_stack.sv
// Return-address stack: circular storage, depth counter, sticky flags.
// Optional macro RAS_ALIGN_CHECK_EN drops misaligned pushes.
module pc_return_stack
  import cpu_pkg::*;
#(
  parameter int DEPTH = RAS_DEPTH_DEF,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic              pop,
  input  logic              flush,
  output logic [ADDR_W-1:0] top_addr,
  output logic              empty,
  output logic              full,
  output logic              overflow,
  output logic              underflow
`ifdef RAS_ALIGN_CHECK_EN
  ,
  output logic              misalign
`endif
);

  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [CNT_W-1:0]  depth_q, depth_d;
  logic              ovf_q, ovf_d;
  logic              udf_q, udf_d;
  logic [PTR_W-1:0]  top_idx;
  logic              we;
  logic [PTR_W-1:0]  waddr;
  logic [ADDR_W-1:0] rdata;
  logic              push_ok;
  logic              is_empty;
  logic              is_full;

`ifdef RAS_ALIGN_CHECK_EN
  logic mis_q, mis_d;
  assign push_ok = push & addr_aligned(push_addr);
`else
  assign push_ok = push;
`endif

  assign top_idx  = ptr_q - PTR_W'(1);
  assign is_empty = depth_q == '0;
  assign is_full  = depth_q == FULL_CNT;

  ras_storage #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_storage (
    .CLK     (CLK),
    .RST     (RST),
    .we_i    (we),
    .waddr_i (waddr),
    .wdata_i (push_addr),
    .raddr_i (top_idx),
    .rdata_o (rdata)
  );

  // Next pointer/depth/flags; flush beats replace beats push beats pop.
  always_comb begin
    ptr_d   = ptr_q;
    depth_d = depth_q;
    ovf_d   = ovf_q;
    udf_d   = udf_q;
    we      = 1'b0;
    waddr   = ptr_q;
    if (flush) begin
      depth_d = '0;
    end else if (push_ok && pop && !is_empty) begin
      we    = 1'b1;
      waddr = top_idx;
    end else if (push_ok) begin
      we    = 1'b1;
      ptr_d = ptr_q + PTR_W'(1);
      if (is_full) begin
        ovf_d = 1'b1;
      end else begin
        depth_d = depth_q + CNT_W'(1);
      end
    end else if (pop) begin
      if (is_empty) begin
        udf_d = 1'b1;
      end else begin
        ptr_d   = top_idx;
        depth_d = depth_q - CNT_W'(1);
      end
    end
  end

`ifdef RAS_ALIGN_CHECK_EN
  // Sticky record of any rejected misaligned push.
  always_comb begin
    mis_d = mis_q;
    if (!flush && push && !push_ok) begin
      mis_d = 1'b1;
    end
  end

  // Misalign flag register, cleared only by reset.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      mis_q <= 1'b0;
    end else begin
      mis_q <= mis_d;
    end
  end

  assign misalign = mis_q;
`endif

  // Pointer, depth and sticky flag registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ptr_q   <= '0;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  assign top_addr  = is_empty ? '0 : rdata;
  assign empty     = is_empty;
  assign full      = is_full;
  assign overflow  = ovf_q;
  assign underflow = udf_q;

endmodule

// File: tb/tb_pc_return_stack.sv
// Directed self-checking bench for pc_return_stack.
// Define RAS_ALIGN_CHECK_EN to also exercise the alignment check.
module tb_pc_return_stack;

  logic        CLK;
  logic        RST;
  logic        push;
  logic [31:0] push_addr;
  logic        pop;
  logic        flush;
  logic [31:0] top_addr;
  logic        empty;
  logic        full;
  logic        overflow;
  logic        underflow;
`ifdef RAS_ALIGN_CHECK_EN
  logic        misalign;
`endif

  int errors = 0;
  int checks = 0;

  pc_return_stack #(
    .DEPTH (8),
    .PTR_W (3)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .push      (push),
    .push_addr (push_addr),
    .pop       (pop),
    .flush     (flush),
    .top_addr  (top_addr),
    .empty     (empty),
    .full      (full),
    .overflow  (overflow),
    .underflow (underflow)
`ifdef RAS_ALIGN_CHECK_EN
    ,
    .misalign  (misalign)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic apply_reset();
    push = 0; pop = 0; flush = 0; push_addr = '0;
    @(negedge CLK);
    RST = 1'b0;
    #3;
    RST = 1'b1;
    @(negedge CLK);
  endtask

  task automatic cycle(input logic p, input logic [31:0] a,
                       input logic po, input logic f);
    push = p; push_addr = a; pop = po; flush = f;
    @(posedge CLK);
    #1;
    push = 0; pop = 0; flush = 0; push_addr = '0;
  endtask

  task automatic test_reset();
    push = 1; push_addr = 32'h0000_0abc; pop = 0; flush = 0;
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    @(posedge CLK);
    #1;
    checks++;
    if (top_addr !== 32'h0 || empty !== 1'b1 || full !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: top=%h empty=%b full=%b, want 0/1/0",
               top_addr, empty, full);
    end
    checks++;
    if (overflow !== 1'b0 || underflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: ovf=%b udf=%b, want 0/0",
               overflow, underflow);
    end
    push = 0;
    RST = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_basic();
    apply_reset();
    cycle(1, 32'h0040_0004, 0, 0);
    cycle(1, 32'h0040_0010, 0, 0);
    checks++;
    if (top_addr !== 32'h0040_0010 || empty !== 1'b0) begin
      errors++;
      $display("FAIL basic_push2: top=%h empty=%b, want 00400010/0",
               top_addr, empty);
    end
    cycle(0, 0, 1, 0);
    checks++;
    if (top_addr !== 32'h0040_0004) begin
      errors++;
      $display("FAIL basic_pop1: top=%h, want 00400004", top_addr);
    end
    cycle(0, 0, 1, 0);
    checks++;
    if (top_addr !== 32'h0 || empty !== 1'b1) begin
      errors++;
      $display("FAIL basic_pop2: top=%h empty=%b, want 0/1",
               top_addr, empty);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] exp;
    apply_reset();
    for (int i = 0; i < 9; i++) begin
      cycle(1, 32'h100 + 32'(4 * i), 0, 0);
      if (i == 6) begin
        checks++;
        if (full !== 1'b0) begin
          errors++;
          $display("FAIL ovf_not_full7: full=%b, want 0", full);
        end
      end
      if (i == 7) begin
        checks++;
        if (full !== 1'b1 || overflow !== 1'b0) begin
          errors++;
          $display("FAIL ovf_full8: full=%b ovf=%b, want 1/0",
                   full, overflow);
        end
      end
    end
    checks++;
    if (overflow !== 1'b1 || full !== 1'b1 || top_addr !== 32'h120) begin
      errors++;
      $display("FAIL ovf_push9: ovf=%b full=%b top=%h, want 1/1/120",
               overflow, full, top_addr);
    end
    for (int i = 0; i < 8; i++) begin
      exp = 32'h120 - 32'(4 * i);
      checks++;
      if (top_addr !== exp) begin
        errors++;
        $display("FAIL ovf_pop%0d: top=%h, want %h", i, top_addr, exp);
      end
      cycle(0, 0, 1, 0);
    end
    checks++;
    if (empty !== 1'b1 || underflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_drained: empty=%b udf=%b, want 1/0",
               empty, underflow);
    end
    cycle(0, 0, 1, 0);
    checks++;
    if (underflow !== 1'b1 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_pop9: udf=%b ovf=%b, want 1/1",
               underflow, overflow);
    end
  endtask

  task automatic test_pop_empty();
    apply_reset();
    cycle(0, 0, 1, 0);
    checks++;
    if (underflow !== 1'b1 || empty !== 1'b1 || top_addr !== 32'h0) begin
      errors++;
      $display("FAIL udf_pop: udf=%b empty=%b top=%h, want 1/1/0",
               underflow, empty, top_addr);
    end
    cycle(1, 32'h200, 0, 0);
    checks++;
    if (top_addr !== 32'h200 || empty !== 1'b0) begin
      errors++;
      $display("FAIL udf_push: top=%h empty=%b, want 200/0",
               top_addr, empty);
    end
    cycle(0, 0, 1, 0);
    checks++;
    if (empty !== 1'b1) begin
      errors++;
      $display("FAIL udf_depth1: empty=%b, want 1", empty);
    end
  endtask

  task automatic test_replace();
    apply_reset();
    cycle(1, 32'h300, 0, 0);
    push = 1; push_addr = 32'h304; pop = 1;
    #1;
    checks++;
    if (top_addr !== 32'h300) begin
      errors++;
      $display("FAIL repl_sample: top=%h, want 300", top_addr);
    end
    @(posedge CLK);
    #1;
    push = 0; pop = 0; push_addr = '0;
    checks++;
    if (top_addr !== 32'h304 || underflow !== 1'b0) begin
      errors++;
      $display("FAIL repl_next: top=%h udf=%b, want 304/0",
               top_addr, underflow);
    end
    cycle(0, 0, 1, 0);
    checks++;
    if (empty !== 1'b1) begin
      errors++;
      $display("FAIL repl_depth: empty=%b, want 1", empty);
    end
    cycle(1, 32'h500, 1, 0);
    checks++;
    if (top_addr !== 32'h500 || underflow !== 1'b0 || empty !== 1'b0) begin
      errors++;
      $display("FAIL repl_empty: top=%h udf=%b empty=%b, want 500/0/0",
               top_addr, underflow, empty);
    end
  endtask

  task automatic test_flush();
    apply_reset();
    cycle(1, 32'h400, 0, 0);
    cycle(1, 32'h404, 0, 0);
    cycle(1, 32'h408, 0, 0);
    cycle(1, 32'h40c, 0, 1);
    checks++;
    if (empty !== 1'b1 || top_addr !== 32'h0 || full !== 1'b0) begin
      errors++;
      $display("FAIL flush_state: empty=%b top=%h full=%b, want 1/0/0",
               empty, top_addr, full);
    end
    cycle(1, 32'h600, 0, 0);
    checks++;
    if (top_addr !== 32'h600) begin
      errors++;
      $display("FAIL flush_push: top=%h, want 600", top_addr);
    end
    cycle(0, 0, 1, 0);
    checks++;
    if (empty !== 1'b1 || overflow !== 1'b0 || underflow !== 1'b0) begin
      errors++;
      $display("FAIL flush_pop: empty=%b ovf=%b udf=%b, want 1/0/0",
               empty, overflow, underflow);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] v;
    apply_reset();
    for (int i = 0; i < 7; i++) begin
      cycle(1, 32'h700 + 32'(4 * i), 0, 0);
    end
    cycle(0, 0, 0, 1);
    for (int i = 0; i < 10; i++) begin
      v = 32'h800 + 32'(8 * i);
      cycle(1, v, 0, 0);
      checks++;
      if (top_addr !== v || empty !== 1'b0) begin
        errors++;
        $display("FAIL wrap_push%0d: top=%h empty=%b, want %h/0",
                 i, top_addr, empty, v);
      end
      cycle(0, 0, 1, 0);
      checks++;
      if (top_addr !== 32'h0 || empty !== 1'b1) begin
        errors++;
        $display("FAIL wrap_pop%0d: top=%h empty=%b, want 0/1",
                 i, top_addr, empty);
      end
    end
    cycle(1, 32'h900, 0, 0);
    cycle(1, 32'h904, 0, 0);
    cycle(0, 0, 1, 0);
    checks++;
    if (top_addr !== 32'h900 || underflow !== 1'b0) begin
      errors++;
      $display("FAIL wrap_final: top=%h udf=%b, want 900/0",
               top_addr, underflow);
    end
  endtask

`ifdef RAS_ALIGN_CHECK_EN
  task automatic test_align();
    apply_reset();
    checks++;
    if (misalign !== 1'b0) begin
      errors++;
      $display("FAIL align_reset: mis=%b, want 0", misalign);
    end
    cycle(1, 32'h0040_0006, 0, 0);
    checks++;
    if (misalign !== 1'b1 || empty !== 1'b1) begin
      errors++;
      $display("FAIL align_drop: mis=%b empty=%b, want 1/1",
               misalign, empty);
    end
    cycle(1, 32'h0040_0008, 0, 0);
    checks++;
    if (top_addr !== 32'h0040_0008 || empty !== 1'b0) begin
      errors++;
      $display("FAIL align_ok: top=%h empty=%b, want 00400008/0",
               top_addr, empty);
    end
    cycle(1, 32'h0040_0001, 1, 0);
    checks++;
    if (empty !== 1'b1 || top_addr !== 32'h0) begin
      errors++;
      $display("FAIL align_pop: empty=%b top=%h, want 1/0",
               empty, top_addr);
    end
  endtask
`endif

  initial begin
    RST = 1'b1;
    push = 0; pop = 0; flush = 0; push_addr = '0;
    test_reset();
    test_basic();
    test_overflow();
    test_pop_empty();
    test_replace();
    test_flush();
    test_wrap();
`ifdef RAS_ALIGN_CHECK_EN
    test_align();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, want finish");
    $fatal(1, "timeout");
  end

endmodule
